ov7670_config_seq: RTL and testbench
====================================

Name: ov7670_config_seq

Overview:
- Sequencer between the OV7670 configuration ROM and the SCCB (I2C-like) master.
- Steps the ROM address from 0 and fetches each 16-bit {reg, value} word.
- Hands each word to the SCCB master as a single register write.
- Handles two ROM markers: 0xFFF0 is an inter-write delay, 0xFFFF is end of table.
- Reports busy, done and error to the camera top level, which releases the capture pipeline once done=1.

Parameters:
- DELAY_CYCLES, 1_000_000: clk cycles waited on a 0xFFF0 entry (10 ms at 100 MHz).
- MAX_RETRY, 3: re-sends of one write after a NACK before aborting.
- ADDR_W, 8: ROM address width.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; begins a configuration run
- rom_addr  out  ADDR_W  ROM index
- rom_clk_en  out  1  ROM read strobe; ROM dout is valid the cycle after
- rom_dout  in  16  ROM word {reg[15:8], value[7:0]}
- sccb_ready  in  1  master idle / transaction complete
- sccb_nack  in  1  valid while sccb_ready=1 following a transaction; 1 = slave NACK
- sccb_start  out  1  one-cycle pulse; launch write
- sccb_reg  out  8  register address
- sccb_data  out  8  register value
- busy  out  1  run in progress
- done  out  1  table completed successfully; sticky
- err  out  1  aborted on retry exhaustion or table overrun; sticky

Behaviour:
- Reset values: all outputs 0; rom_addr=0; retry count 0; delay counter 0; state IDLE.
- rst at any cycle, including mid-transaction or mid-delay, returns to IDLE within that edge and drops sccb_start.
- States and transitions:
  - IDLE: on start=1, rom_addr←0, clear done/err, busy←1, go to FETCH. start is ignored in every other state. In DONE/ERR, start=1 behaves as in IDLE and restarts from address 0.
  - FETCH (1 cycle): rom_clk_en=1, go to DECODE.
  - DECODE (1 cycle): sample rom_dout.
    - 0xFFFF → DONE.
    - 0xFFF0 → DELAY with counter←0.
    - Otherwise latch sccb_reg/sccb_data, retry count←0, go to SEND.
  - SEND: wait for sccb_ready=1. In the cycle it is seen high, sccb_start=1 for exactly that cycle, then go to WAIT_BUSY.
  - WAIT_BUSY: wait for sccb_ready=0. Prevents mistaking the pre-start ready for completion.
  - WAIT_DONE: on sccb_ready=1, sample sccb_nack.
    - nack=0 → ADVANCE.
    - nack=1 and retry<MAX_RETRY → retry+1, SEND.
    - nack=1 and retry=MAX_RETRY → ERR.
  - DELAY: counter increments each cycle. When counter=DELAY_CYCLES-1, go to ADVANCE (DELAY_CYCLES cycles in DELAY).
  - ADVANCE (1 cycle): if rom_addr=2^ADDR_W-1, go to ERR (overrun, no wrap). Otherwise rom_addr+1, go to FETCH.
  - DONE: busy=0, done=1.
  - ERR: busy=0, err=1. rom_addr holds the failing index.
- Latency: start sampled at edge N → rom_clk_en high in cycle N+1 → DECODE in N+2 → earliest sccb_start in cycle N+3.
- sccb_reg/sccb_data are held constant from DECODE until the next DECODE. rom_addr only changes in IDLE and ADVANCE.
- busy=1 in every state except IDLE/DONE/ERR. done and err are never both 1.
- Counter widths: delay counter is ceil(log2(DELAY_CYCLES)) bits; retry counter is ceil(log2(MAX_RETRY+1)) bits.

Test Plan:
- Nominal: ROM model {0x1280, 0x1200, 0xFFFF}, master acks after 5 cycles → exactly two sccb_start pulses carrying (0x12,0x80) then (0x12,0x00); done=1, busy=0, rom_addr=2; first sccb_start 3 cycles after start.
- Delay: ROM {0x1280, 0xFFF0, 0x1100, 0xFFFF}, DELAY_CYCLES=16 → exactly 16 cycles in DELAY, no sccb_start between the first write's completion and the 0x11 write; done=1.
- NACK retry: first write NACKs twice then acks, MAX_RETRY=3 → 3 sccb_start pulses with identical reg/data; run completes with done=1, err=0. Always NACK → 4 pulses, then err=1, rom_addr=0.
- Overrun: ROM returns 0x1234 for every address, ADDR_W=3 → 8 writes, then err=1, rom_addr=7.
- Reset mid-run: assert rst during WAIT_DONE and again mid-DELAY → next cycle all outputs 0, state IDLE; a subsequent start replays from address 0.
- Start while busy and ready held low: start pulses in SEND/DELAY ignored, no extra sccb_start; SEND stalls with sccb_start=0 until ready rises.

Source files
------------

// File: rtl/ov7670_config_seq_if.sv
// SCCB write-request channel between the configuration sequencer (master)
// and the SCCB bus engine (slave).
interface ov7670_config_seq_if;
    logic       sccb_start;
    logic [7:0] sccb_reg;
    logic [7:0] sccb_data;
    logic       sccb_ready;
    logic       sccb_nack;

    modport master (
        output sccb_start,
        output sccb_reg,
        output sccb_data,
        input  sccb_ready,
        input  sccb_nack
    );

    modport slave (
        input  sccb_start,
        input  sccb_reg,
        input  sccb_data,
        output sccb_ready,
        output sccb_nack
    );
endinterface

// File: rtl/ov7670_config_seq.sv
// Walks the OV7670 configuration ROM and issues one SCCB register write per
// entry, honouring the 0xFFF0 delay marker and the 0xFFFF end-of-table marker.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// IDLE      | waiting for start after reset
// FETCH     | ROM read strobe for rom_addr
// DECODE    | classify ROM word: end, delay, or register write
// SEND      | wait for master ready, pulse sccb_start
// WAIT_BUSY | wait for master to drop ready (transaction accepted)
// WAIT_DONE | wait for completion, retry on NACK
// DELAY     | inter-write settling delay
// ADVANCE   | step to next ROM entry, abort on table overrun
// DONE      | table finished; sticky done
// ERR       | retry exhaustion or overrun; sticky err, rom_addr = failing entry
module ov7670_config_seq #(
    parameter int DELAY_CYCLES = 1_000_000,
    parameter int MAX_RETRY    = 3,
    parameter int ADDR_W       = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic [ADDR_W-1:0]     rom_addr,
    output logic                  rom_clk_en,
    input  logic [15:0]           rom_dout,
    ov7670_config_seq_if.master   sccb,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int DLY_W = (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES) : 1;
    localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [DLY_W-1:0]  DLY_LAST  = DLY_W'(DELAY_CYCLES - 1);
    localparam logic [RTY_W-1:0]  RTY_MAX   = RTY_W'(MAX_RETRY);
    localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

    typedef enum logic [3:0] {
        IDLE, FETCH, DECODE, SEND, WAIT_BUSY, WAIT_DONE, DELAY, ADVANCE, DONE, ERR
    } state_t;

    state_t            state;
    logic [DLY_W-1:0]  dly_cnt;
    logic [RTY_W-1:0]  retry;

    // Launch in the same cycle ready is observed so the master sees the
    // request on the edge where the sequencer leaves SEND.
    assign sccb.sccb_start = (state == SEND) && sccb.sccb_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            rom_addr       <= '0;
            rom_clk_en     <= 1'b0;
            sccb.sccb_reg  <= '0;
            sccb.sccb_data <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            err            <= 1'b0;
            retry          <= '0;
            dly_cnt        <= '0;
        end else begin
            rom_clk_en <= 1'b0;
            case (state)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        rom_addr   <= '0;
                        done       <= 1'b0;
                        err        <= 1'b0;
                        busy       <= 1'b1;
                        rom_clk_en <= 1'b1;
                        state      <= FETCH;
                    end
                end
                FETCH: state <= DECODE;
                DECODE: begin
                    if (rom_dout == 16'hFFFF) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else if (rom_dout == 16'hFFF0) begin
                        dly_cnt <= '0;
                        state   <= DELAY;
                    end else begin
                        sccb.sccb_reg  <= rom_dout[15:8];
                        sccb.sccb_data <= rom_dout[7:0];
                        retry          <= '0;
                        state          <= SEND;
                    end
                end
                SEND: begin
                    if (sccb.sccb_ready) state <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (!sccb.sccb_ready) state <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (sccb.sccb_ready) begin
                        if (!sccb.sccb_nack) begin
                            state <= ADVANCE;
                        end else if (retry < RTY_MAX) begin
                            retry <= retry + RTY_W'(1);
                            state <= SEND;
                        end else begin
                            busy  <= 1'b0;
                            err   <= 1'b1;
                            state <= ERR;
                        end
                    end
                end
                DELAY: begin
                    dly_cnt <= dly_cnt + DLY_W'(1);
                    if (dly_cnt == DLY_LAST) state <= ADVANCE;
                end
                ADVANCE: begin
                    // No wrap: a table without an end marker is a build error.
                    if (rom_addr == ADDR_LAST) begin
                        busy  <= 1'b0;
                        err   <= 1'b1;
                        state <= ERR;
                    end else begin
                        rom_addr   <= rom_addr + ADDR_W'(1);
                        rom_clk_en <= 1'b1;
                        state      <= FETCH;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ov7670_config_seq.sv
// Directed bench: ROM model, SCCB master model with NACK injection, and a
// scoreboard of expected {reg,data} writes checked at every sccb_start.
module tb_ov7670_config_seq;

    localparam int DLY = 16;
    localparam int AW  = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] rom_addr;
    logic          rom_clk_en;
    logic [15:0]   rom_dout = 16'h0000;
    logic          busy, done, err;

    ov7670_config_seq_if sif ();

    ov7670_config_seq #(.DELAY_CYCLES(DLY), .MAX_RETRY(3), .ADDR_W(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .rom_addr   (rom_addr),
        .rom_clk_en (rom_clk_en),
        .rom_dout   (rom_dout),
        .sccb       (sif.master),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    logic [15:0] rom [8];
    always @(posedge clk) if (rom_clk_en) rom_dout <= rom[rom_addr];

    int n_asserts = 0;
    int n_fail    = 0;
    int n_pulses  = 0;
    logic [15:0] exp_q [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_asserts++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // SCCB master model: ready drops the cycle after a launch, completes 5 cycles later.
    logic ready_int = 1'b1;
    logic nack_r    = 1'b0;
    logic hold_low  = 1'b0;
    logic pending   = 1'b0;
    int   cnt       = 0;
    int   nacks_left = 0;
    logic always_nack = 1'b0;
    assign sif.sccb_ready = ready_int & ~hold_low;
    assign sif.sccb_nack  = nack_r;

    always @(negedge clk) begin
        if (rst) begin
            ready_int = 1'b1;
            nack_r    = 1'b0;
            pending   = 1'b0;
            cnt       = 0;
        end else begin
            if (pending) begin
                pending   = 1'b0;
                ready_int = 1'b0;
                nack_r    = 1'b0;
                cnt       = 5;
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    ready_int = 1'b1;
                    nack_r    = always_nack || (nacks_left > 0);
                    if (nacks_left > 0) nacks_left--;
                end
            end
            if (sif.sccb_start) begin
                logic [15:0] e;
                n_pulses++;
                pending = 1'b1;
                check("sb_expected_write", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("sb_write", {16'h0, sif.sccb_reg, sif.sccb_data}, {16'h0, e});
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_end(input string tag);
        for (int i = 0; i < 3000 && !(done || err); i++) tick();
        check({tag, "_finished"}, 32'(done | err), 32'd1);
    endtask

    task automatic check_zero(input string tag);
        check(tag, 32'({rom_addr, rom_clk_en, sif.sccb_start, sif.sccb_reg,
                        sif.sccb_data, busy, done, err}), 32'd0);
    endtask

    task automatic load_nominal();
        rom = '{16'h1280, 16'h1200, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
    endtask

    task automatic load_delay();
        rom = '{16'h1280, 16'hFFF0, 16'h1100, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
    endtask

    initial begin
        int p0;
        int a1;

        // Reset state
        load_nominal();
        tick();
        tick();
        check_zero("reset_outputs");
        rst = 1'b0;
        tick();
        check_zero("idle_outputs");

        // Nominal run with latency check
        exp_q.push_back(16'h1280);
        exp_q.push_back(16'h1200);
        p0 = n_pulses;
        pulse_start();
        check("fetch_rom_clk_en", 32'(rom_clk_en), 32'd1);
        check("fetch_busy", 32'(busy), 32'd1);
        tick();
        check("decode_no_start", 32'(sif.sccb_start), 32'd0);
        tick();
        check("first_start_latency", 32'(sif.sccb_start), 32'd1);
        wait_end("nominal");
        check("nominal_done", 32'({done, err, busy}), 32'b100);
        check("nominal_addr", 32'(rom_addr), 32'd2);
        check("nominal_pulses", 32'(n_pulses - p0), 32'd2);
        check("nominal_reg_data_held", 32'({sif.sccb_reg, sif.sccb_data}), 32'h1200);
        check("nominal_queue_empty", 32'(exp_q.size()), 32'd0);

        // Delay run, with start pulsed mid-delay (must be ignored)
        load_delay();
        exp_q.push_back(16'h1280);
        exp_q.push_back(16'h1100);
        p0 = n_pulses;
        a1 = 0;
        pulse_start();
        check("restart_clears_done", 32'(done), 32'd0);
        for (int i = 0; i < 3000 && !(done || err); i++) begin
            if (rom_addr == AW'(1)) begin
                a1++;
                start = (a1 == 8);
            end else begin
                start = 1'b0;
            end
            tick();
        end
        start = 1'b0;
        check("delay_finished", 32'(done | err), 32'd1);
        check("delay_addr1_cycles", 32'(a1), 32'(DLY + 3));
        check("delay_done", 32'({done, err, busy}), 32'b100);
        check("delay_pulses", 32'(n_pulses - p0), 32'd2);
        check("delay_addr", 32'(rom_addr), 32'd3);

        // NACK twice, then ack
        load_nominal();
        nacks_left = 2;
        repeat (3) exp_q.push_back(16'h1280);
        exp_q.push_back(16'h1200);
        p0 = n_pulses;
        pulse_start();
        wait_end("retry");
        check("retry_done", 32'({done, err, busy}), 32'b100);
        check("retry_pulses", 32'(n_pulses - p0), 32'd4);

        // Always NACK: retries exhausted
        always_nack = 1'b1;
        repeat (4) exp_q.push_back(16'h1280);
        p0 = n_pulses;
        pulse_start();
        wait_end("nack_abort");
        check("nack_abort_flags", 32'({done, err, busy}), 32'b010);
        check("nack_abort_addr", 32'(rom_addr), 32'd0);
        check("nack_abort_pulses", 32'(n_pulses - p0), 32'd4);
        always_nack = 1'b0;
        nack_r = 1'b0;

        // Overrun: no end marker anywhere
        rom = '{default: 16'h1234};
        repeat (8) exp_q.push_back(16'h1234);
        p0 = n_pulses;
        pulse_start();
        wait_end("overrun");
        check("overrun_flags", 32'({done, err, busy}), 32'b010);
        check("overrun_addr", 32'(rom_addr), 32'd7);
        check("overrun_pulses", 32'(n_pulses - p0), 32'd8);

        // Reset during WAIT_DONE, then replay
        load_nominal();
        exp_q.push_back(16'h1280);
        exp_q.push_back(16'h1200);
        p0 = n_pulses;
        pulse_start();
        for (int i = 0; i < 50 && n_pulses == p0; i++) tick();
        check("rst_wd_first_pulse", 32'(n_pulses - p0), 32'd1);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_zero("rst_wait_done_outputs");
        exp_q.delete();
        exp_q.push_back(16'h1280);
        exp_q.push_back(16'h1200);
        p0 = n_pulses;
        pulse_start();
        wait_end("replay");
        check("replay_done", 32'({done, err, busy}), 32'b100);
        check("replay_addr", 32'(rom_addr), 32'd2);
        check("replay_pulses", 32'(n_pulses - p0), 32'd2);

        // Reset mid-delay
        load_delay();
        exp_q.push_back(16'h1280);
        exp_q.push_back(16'h1100);
        pulse_start();
        for (int i = 0; i < 200 && rom_addr != AW'(1); i++) tick();
        check("rst_dly_reached", 32'(rom_addr), 32'd1);
        repeat (5) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_zero("rst_delay_outputs");
        exp_q.delete();

        // Start ignored while SEND stalls on ready low
        load_nominal();
        hold_low = 1'b1;
        exp_q.push_back(16'h1280);
        exp_q.push_back(16'h1200);
        p0 = n_pulses;
        pulse_start();
        repeat (4) tick();
        pulse_start();
        repeat (3) tick();
        check("stall_no_start", 32'(sif.sccb_start), 32'd0);
        check("stall_busy_addr", 32'({busy, rom_addr}), 32'({1'b1, 3'd0}));
        check("stall_no_pulses", 32'(n_pulses - p0), 32'd0);
        hold_low = 1'b0;
        wait_end("stall");
        check("stall_done", 32'({done, err, busy}), 32'b100);
        check("stall_pulses", 32'(n_pulses - p0), 32'd2);
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
